// File: rtl/debugval_ctrl_pkg.sv
// Shared types for the debug-page controller: page encoding and default debounce length.
// Pure declarations; no timing or flow control.
package debug_pkg;

  typedef enum logic [1:0] {
    PAGE_PC    = 2'd0,
    PAGE_INSTR = 2'd1,
    PAGE_ALU   = 2'd2,
    PAGE_WDATA = 2'd3
  } page_t;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 500000;

  function automatic page_t next_page(input page_t p);
    return page_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/debugval_ctrl_if.sv
// Core observation bus into the debug-page controller and its display-side outputs.
// master = core/board side driving sources; slave = controller.
interface debugval_ctrl_if;
  import debug_pkg::*;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] debugval;
  page_t       sel;
  logic        frozen;

  modport master (
    output pc, instr, aluout, writedata, memwrite,
    input  debugval, sel, frozen
  );

  modport slave (
    input  pc, instr, aluout, writedata, memwrite,
    output debugval, sel, frozen
  );

endinterface

// File: rtl/debugval_ctrl_debounce.sv
// Push-button conditioner: 2-flop sync, stability counter, rising-edge pulse on accept.
// Pulse registers DEBOUNCE_CYCLES+2 edges after a clean raw edge; no backpressure.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = debug_pkg::DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where synced and accepted levels agree restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/debugval_ctrl.sv
// Debug-page controller: page select, freeze toggle, registered debugval (1-cycle latency).
// STORE_CAPTURE_EN: page 3 shows the last stored value instead of live writedata.
module debugval_ctrl
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_next,
  input  logic            btn_freeze,
  debugval_ctrl_if.slave  bus
);

  logic        next_pulse;
  logic        freeze_pulse;
  logic [31:0] page3_val;
  logic [31:0] src;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_next),
    .pulse   (next_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_freeze_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_freeze),
    .pulse   (freeze_pulse)
  );

`ifdef STORE_CAPTURE_EN
  logic [31:0] store_q;

  // Captures even while frozen so the page is current on unfreeze
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q <= '0;
    end else if (bus.memwrite) begin
      store_q <= bus.writedata;
    end
  end

  assign page3_val = store_q;
`else
  logic unused_memwrite;
  assign unused_memwrite = bus.memwrite;
  assign page3_val       = bus.writedata;
`endif

  always_comb begin
    src = bus.pc;
    unique case (bus.sel)
      PAGE_PC:    src = bus.pc;
      PAGE_INSTR: src = bus.instr;
      PAGE_ALU:   src = bus.aluout;
      PAGE_WDATA: src = page3_val;
      default:    src = bus.pc;
    endcase
  end

  // A next press coinciding with a freeze press is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sel      <= PAGE_PC;
      bus.frozen   <= 1'b0;
      bus.debugval <= '0;
    end else begin
      if (freeze_pulse) begin
        bus.frozen <= ~bus.frozen;
      end
      if (next_pulse && !bus.frozen && !freeze_pulse) begin
        bus.sel <= next_page(bus.sel);
      end
      if (!bus.frozen) begin
        bus.debugval <= src;
      end
    end
  end

endmodule
